// File: rtl/note_lane_pkg.sv
// Shared constants for the multi-lane note scroller.
// Glyph codes feed the LCD character path directly.
package note_lane_pkg;

    localparam logic [7:0] NOTE_CHAR  = 8'h4F;
    localparam logic [7:0] SPACE_CHAR = 8'h20;
    localparam int         MAX_LANES  = 8;

endpackage

// File: rtl/note_lane_shift.sv
// One note lane: shift cells, pending spawn slot, column clear and miss pulse.
// Clears address pre-shift positions so a clear and a shift may share a cycle.
module note_lane_shift
    import note_lane_pkg::*;
#(
    parameter int COLS    = 16,
    parameter int PITCH_W = 32,
    parameter int CW      = $clog2(COLS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               shift,
    input  logic               cap,
    input  logic [PITCH_W-1:0] pitch,
    input  logic               clr,
    input  logic [CW-1:0]      clr_col,
    output logic [COLS-1:0]    occ,
    output logic [PITCH_W-1:0] pitch0,
    output logic               miss
);

    logic [COLS-1:0][PITCH_W-1:0] pit;
    logic [COLS-1:0][PITCH_W-1:0] pit_n;
    logic [COLS-1:0]              occ_n;
    logic                         pend;
    logic [PITCH_W-1:0]           pend_pit;
    logic                         clr_ok;
    logic                         clr0;
    logic [CW-1:0]                prev_col;

    assign clr_ok   = clr && (32'(clr_col) < COLS);
    assign clr0     = clr_ok && (clr_col == '0);
    assign prev_col = clr_col - CW'(1);
    assign pitch0   = pit[0];

    always_comb begin
        occ_n = occ;
        pit_n = pit;
        if (shift) begin
            for (int c = 0; c < COLS - 1; c++) begin
                occ_n[c] = occ[c+1];
                pit_n[c] = pit[c+1];
            end
            // pend_pit is held at zero whenever pend is clear
            occ_n[COLS-1] = pend;
            pit_n[COLS-1] = pend_pit;
            if (clr_ok && !clr0) begin
                occ_n[prev_col] = 1'b0;
                pit_n[prev_col] = '0;
            end
        end else if (clr_ok) begin
            occ_n[clr_col] = 1'b0;
            pit_n[clr_col] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            occ      <= '0;
            pit      <= '0;
            pend     <= 1'b0;
            pend_pit <= '0;
            miss     <= 1'b0;
        end else begin
            occ  <= occ_n;
            pit  <= pit_n;
            miss <= shift && occ[0] && !clr0;
            if (cap) begin
                pend     <= 1'b1;
                pend_pit <= pitch;
            end else if (shift) begin
                pend     <= 1'b0;
                pend_pit <= '0;
            end
        end
    end

endmodule

// File: rtl/note_lane_scroller.sv
// N-lane note scroller: scroll timer, per-lane shifters and LCD read port.
// The period is sampled at each wrap so a change never truncates a running interval.
module note_lane_scroller
    import note_lane_pkg::*;
#(
    parameter int N_LANES  = 2,
    parameter int COLS     = 16,
    parameter int PITCH_W  = 32,
    parameter int WIN      = 2,
    parameter int PERIOD_W = 16,
    localparam int CW      = $clog2(COLS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_tick,
    input  logic                       i_run,
    input  logic                       i_flush,
    input  logic [PERIOD_W-1:0]        i_period,
    input  logic [N_LANES-1:0]         i_note,
    input  logic [N_LANES*PITCH_W-1:0] i_pitch,
    input  logic [N_LANES-1:0]         i_clr,
    input  logic [N_LANES*CW-1:0]      i_clr_col,
    input  logic [2:0]                 i_rd_lane,
    input  logic [CW-1:0]              i_rd_col,
    output logic [7:0]                 o_rd_char,
    output logic [N_LANES*WIN-1:0]     o_win,
    output logic [N_LANES*PITCH_W-1:0] o_pitch0,
    output logic [N_LANES-1:0]         o_miss,
    output logic                       o_shift
);

    logic [PERIOD_W-1:0]             cnt;
    logic [PERIOD_W-1:0]             per_q;
    logic [PERIOD_W-1:0]             lim;
    logic                            shift_en;
    logic [MAX_LANES-1:0][COLS-1:0]  occ_all;
    logic                            rd_hit;

    assign lim = (i_period == '0) ? '0 : i_period - PERIOD_W'(1);
    assign shift_en = i_run && i_tick && (cnt == '0) && !i_flush;

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            cnt     <= '0;
            per_q   <= lim;
            o_shift <= 1'b0;
        end else begin
            o_shift <= shift_en;
            if (i_run && i_tick) begin
                if (cnt >= per_q) begin
                    cnt   <= '0;
                    per_q <= lim;
                end else begin
                    cnt <= cnt + PERIOD_W'(1);
                end
            end
        end
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        note_lane_shift #(
            .COLS    (COLS),
            .PITCH_W (PITCH_W),
            .CW      (CW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .flush   (i_flush),
            .shift   (shift_en),
            .cap     (i_note[l] && i_run),
            .pitch   (i_pitch[l*PITCH_W +: PITCH_W]),
            .clr     (i_clr[l]),
            .clr_col (i_clr_col[l*CW +: CW]),
            .occ     (occ_all[l]),
            .pitch0  (o_pitch0[l*PITCH_W +: PITCH_W]),
            .miss    (o_miss[l])
        );
        assign o_win[l*WIN +: WIN] = occ_all[l][WIN-1:0];
    end

    for (genvar l = N_LANES; l < MAX_LANES; l++) begin : g_pad
        assign occ_all[l] = '0;
    end

    assign rd_hit = (32'(i_rd_lane) < N_LANES)
                 && (32'(i_rd_col) < COLS)
                 && occ_all[i_rd_lane][i_rd_col];

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_rd_char <= SPACE_CHAR;
        end else begin
            o_rd_char <= rd_hit ? NOTE_CHAR : SPACE_CHAR;
        end
    end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Scoreboard bench for note_lane_scroller (2 lanes x 16 cols).
// Expected shift snapshots and read glyphs are queued by stimulus and popped by a monitor.
module tb_note_lane_scroller;

    typedef struct packed {
        logic [3:0]  win;
        logic [63:0] p0;
        logic [1:0]  miss;
    } exp_t;

    typedef struct packed {
        logic [2:0] l;
        logic [3:0] c;
        logic [7:0] ch;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tick;
    logic        i_run;
    logic        i_flush;
    logic [15:0] i_period;
    logic [1:0]  i_note;
    logic [63:0] i_pitch;
    logic [1:0]  i_clr;
    logic [7:0]  i_clr_col;
    logic [2:0]  i_rd_lane;
    logic [3:0]  i_rd_col;
    logic [7:0]  o_rd_char;
    logic [3:0]  o_win;
    logic [63:0] o_pitch0;
    logic [1:0]  o_miss;
    logic        o_shift;

    exp_t sq[$];
    rd_t  rq[$];
    exp_t e;
    rd_t  r;
    int   errors = 0;
    int   checks = 0;
    int   sidx = 0;
    logic mon_en = 1'b0;
    logic rd_req = 1'b0;
    logic rd_req_d = 1'b0;

    note_lane_scroller dut (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (i_tick),
        .i_run     (i_run),
        .i_flush   (i_flush),
        .i_period  (i_period),
        .i_note    (i_note),
        .i_pitch   (i_pitch),
        .i_clr     (i_clr),
        .i_clr_col (i_clr_col),
        .i_rd_lane (i_rd_lane),
        .i_rd_col  (i_rd_col),
        .o_rd_char (o_rd_char),
        .o_win     (o_win),
        .o_pitch0  (o_pitch0),
        .o_miss    (o_miss),
        .o_shift   (o_shift)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_req_d <= rd_req;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_shift) begin
                sidx++;
                checks++;
                if (sq.size() == 0) begin
                    errors++;
                    $display("FAIL shift_unexp #%0d got o_shift=1 want none", sidx);
                end else begin
                    e = sq.pop_front();
                    if (o_win !== e.win) begin
                        errors++;
                        $display("FAIL win #%0d got %b want %b", sidx, o_win, e.win);
                    end
                    checks++;
                    if (o_pitch0 !== e.p0) begin
                        errors++;
                        $display("FAIL pitch0 #%0d got %h want %h", sidx, o_pitch0, e.p0);
                    end
                    checks++;
                    if (o_miss !== e.miss) begin
                        errors++;
                        $display("FAIL miss #%0d got %b want %b", sidx, o_miss, e.miss);
                    end
                end
            end else if (o_miss != 2'b00) begin
                checks++;
                errors++;
                $display("FAIL miss_unexp got %b want 00 (no shift)", o_miss);
            end
            if (rd_req_d) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL rd_unexp got read with empty queue");
                end else begin
                    r = rq.pop_front();
                    if (o_rd_char !== r.ch) begin
                        errors++;
                        $display("FAIL rd(%0d,%0d) got %h want %h", r.l, r.c, o_rd_char, r.ch);
                    end
                end
            end
        end
    end

    function automatic exp_t mk(input logic [3:0] w, input logic [31:0] p1,
                                input logic [31:0] p0, input logic [1:0] m);
        exp_t x;
        x.win  = w;
        x.p0   = {p1, p0};
        x.miss = m;
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        i_tick = 1'b0;
        i_note = '0;
        i_clr  = '0;
        rd_req = 1'b0;
    endtask

    task automatic drive(input logic t, input logic [1:0] n,
                         input logic [31:0] p1, input logic [31:0] p0,
                         input logic [1:0] c, input logic [3:0] c1,
                         input logic [3:0] c0);
        i_tick    = t;
        i_note    = n;
        i_pitch   = {p1, p0};
        i_clr     = c;
        i_clr_col = {c1, c0};
        step();
    endtask

    task automatic tick_idle();
        drive(1'b1, 2'b00, 0, 0, 2'b00, 4'd0, 4'd0);
        step();
    endtask

    task automatic grp(input exp_t x, input logic [1:0] n,
                       input logic [31:0] p1, input logic [31:0] p0,
                       input logic [1:0] c, input logic [3:0] c1,
                       input logic [3:0] c0);
        sq.push_back(x);
        drive(1'b1, n, p1, p0, c, c1, c0);
        step();
        tick_idle();
        tick_idle();
    endtask

    task automatic rd(input int l, input int c, input logic [7:0] ch);
        rd_t q;
        q.l = 3'(l);
        q.c = 4'(c);
        q.ch = ch;
        rq.push_back(q);
        i_rd_lane = 3'(l);
        i_rd_col  = 4'(c);
        rd_req    = 1'b1;
        step();
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  w;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] np1;
        logic [1:0]  m;
        logic [1:0]  n;
        logic [1:0]  c;
        logic [3:0]  c0;

        rst = 1'b0;
        i_tick = 1'b0;
        i_run = 1'b1;
        i_flush = 1'b0;
        i_period = 16'd3;
        i_note = '0;
        i_pitch = '0;
        i_clr = '0;
        i_clr_col = '0;
        i_rd_lane = '0;
        i_rd_col = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_win", 64'(o_win), 64'd0);
        chk("rst_miss", 64'(o_miss), 64'd0);
        chk("rst_shift", 64'(o_shift), 64'd0);
        chk("rst_pitch0", o_pitch0, 64'd0);
        chk("rst_rdchar", 64'(o_rd_char), 64'h20);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < 16; k++)
                rd(l, k, 8'h20);

        // lane0 pitch 440 scrolls to col 0 then falls out as a miss
        drive(1'b0, 2'b01, 0, 440, 2'b00, 4'd0, 4'd0);
        for (int s = 1; s <= 17; s++) begin
            w  = (s == 15) ? 4'b0010 : (s == 16) ? 4'b0001 : 4'b0000;
            p0 = (s == 16) ? 32'd440 : 32'd0;
            m  = (s == 17) ? 2'b01 : 2'b00;
            grp(mk(w, 0, p0, m), 2'b00, 0, 0, 2'b00, 4'd0, 4'd0);
            if (s == 1) begin
                rd(0, 15, 8'h4F);
                rd(0, 14, 8'h20);
            end
            if (s == 16) begin
                rd(0, 0, 8'h4F);
                rd(1, 0, 8'h20);
            end
        end

        // clear-on-shift at col 0, note on shift cycle, merged notes
        drive(1'b0, 2'b01, 0, 11, 2'b00, 4'd0, 4'd0);
        for (int s = 1; s <= 19; s++) begin
            w = '0; p0 = 0; p1 = 0; m = '0; n = '0; c = '0; np1 = 0;
            case (s)
                1:  begin n = 2'b10; np1 = 7; end
                15: w = 4'b0010;
                16: begin w = 4'b1001; p0 = 11; end
                17: begin w = 4'b1100; p1 = 7; c = 2'b01; end
                18: begin w = 4'b0100; p1 = 9; m = 2'b10; end
                19: c = 2'b10;
                default: ;
            endcase
            grp(mk(w, p1, p0, m), n, np1, 0, c, 4'd0, 4'd0);
            if (s == 2) begin
                drive(1'b0, 2'b10, 5, 0, 2'b00, 4'd0, 4'd0);
                drive(1'b0, 2'b10, 9, 0, 2'b00, 4'd0, 4'd0);
            end
            if (s == 3) begin
                rd(1, 15, 8'h4F);
                rd(1, 14, 8'h4F);
                rd(1, 13, 8'h20);
            end
        end

        // idle clear of col 2, clear of col 1 on a shift cycle
        drive(1'b0, 2'b11, 8, 3, 2'b00, 4'd0, 4'd0);
        for (int s = 1; s <= 17; s++) begin
            w  = (s == 15) ? 4'b0010 : 4'b0000;
            c  = (s == 16) ? 2'b01 : 2'b00;
            c0 = (s == 16) ? 4'd1 : 4'd0;
            grp(mk(w, 0, 0, 2'b00), 2'b00, 0, 0, c, 4'd0, c0);
            if (s == 14) begin
                drive(1'b0, 2'b00, 0, 0, 2'b10, 4'd2, 4'd0);
                rd(1, 2, 8'h20);
                rd(0, 2, 8'h4F);
            end
        end

        // freeze, ignored note, flush, zero period
        drive(1'b0, 2'b01, 0, 21, 2'b00, 4'd0, 4'd0);
        for (int s = 1; s <= 3; s++)
            grp(mk(4'b0, 0, 0, 2'b00), 2'b00, 0, 0, 2'b00, 4'd0, 4'd0);
        rd(0, 13, 8'h4F);
        rd(2, 13, 8'h20);
        i_run = 1'b0;
        drive(1'b0, 2'b10, 99, 0, 2'b00, 4'd0, 4'd0);
        repeat (10) tick_idle();
        rd(0, 13, 8'h4F);
        rd(1, 15, 8'h20);
        i_run = 1'b1;
        grp(mk(4'b0, 0, 0, 2'b00), 2'b00, 0, 0, 2'b00, 4'd0, 4'd0);
        rd(0, 12, 8'h4F);
        rd(1, 15, 8'h20);
        rd(1, 14, 8'h20);
        drive(1'b0, 2'b01, 0, 5, 2'b00, 4'd0, 4'd0);
        i_period = 16'd0;
        i_flush = 1'b1;
        step();
        i_flush = 1'b0;
        rd(0, 12, 8'h20);
        for (int k = 0; k < 2; k++) begin
            sq.push_back(mk(4'b0, 0, 0, 2'b00));
            tick_idle();
        end
        rd(0, 15, 8'h20);
        rd(0, 14, 8'h20);
        drive(1'b0, 2'b10, 42, 0, 2'b00, 4'd0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            sq.push_back(mk(4'b0, 0, 0, 2'b00));
            tick_idle();
        end
        rd(1, 14, 8'h4F);
        rd(1, 15, 8'h20);

        repeat (3) step();
        chk("shift_q_left", 64'(sq.size()), 64'd0);
        chk("rd_q_left", 64'(rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
